// File: rtl/spi_host_arbiter.sv
// spi_host_arbiter: round-robin sharing of one spi_host_core among NumReq requesters.
// A grant is held across CSAAT-chained segments until the core goes idle.
module spi_host_arbiter #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned CmdWidth = 64,
    parameter int unsigned IdxW     = $clog2(NumReq)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             sw_rst_i,
    input  logic [NumReq-1:0][CmdWidth-1:0]  req_cmd_i,
    input  logic [NumReq-1:0]                req_csaat_i,
    input  logic [NumReq-1:0]                req_cmd_valid_i,
    output logic [NumReq-1:0]                req_cmd_ready_o,
    input  logic [NumReq-1:0][31:0]          req_tx_data_i,
    input  logic [NumReq-1:0][3:0]           req_tx_be_i,
    input  logic [NumReq-1:0]                req_tx_valid_i,
    output logic [NumReq-1:0]                req_tx_ready_o,
    output logic [31:0]                      req_rx_data_o,
    output logic [NumReq-1:0]                req_rx_valid_o,
    input  logic [NumReq-1:0]                req_rx_ready_i,
    output logic [CmdWidth-1:0]              core_command_o,
    output logic                             core_command_valid_o,
    input  logic                             core_command_ready_i,
    output logic [31:0]                      core_tx_data_o,
    output logic [3:0]                       core_tx_be_o,
    output logic                             core_tx_valid_o,
    input  logic                             core_tx_ready_i,
    input  logic [31:0]                      core_rx_data_i,
    input  logic                             core_rx_valid_i,
    output logic                             core_rx_ready_o,
    input  logic                             core_active_i,
    output logic [NumReq-1:0]                grant_o,
    output logic [IdxW-1:0]                  owner_o,
    output logic                             busy_o
);
    typedef enum logic [1:0] {Idle, Lock, Drain} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d, ptr_q, ptr_d;
    logic            first_q, first_d;
    logic [IdxW-1:0] scan, pick;
    logic            found, locked, routed;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            scan = IdxW'((32'(ptr_q) + k) % NumReq);
            if (!found && req_cmd_valid_i[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        first_d = 1'b0;
        if (sw_rst_i) begin
            state_d = Idle;
            owner_d = '0;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                Idle: if (found) begin
                    state_d = Lock;
                    owner_d = pick;
                    ptr_d   = IdxW'((32'(pick) + 1) % NumReq);
                end
                Lock: if (req_cmd_valid_i[owner_q] && core_command_ready_i && !req_csaat_i[owner_q]) begin
                    state_d = Drain;
                    first_d = 1'b1;
                end
                // the core may not have raised active yet on the first drain cycle
                Drain: if (!first_q && !core_active_i) state_d = Idle;
                default: state_d = Idle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            owner_q <= '0;
            ptr_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
        end
    end

    assign locked = state_q == Lock;
    assign routed = state_q != Idle;

    always_comb begin
        grant_o         = '0;
        req_cmd_ready_o = '0;
        req_tx_ready_o  = '0;
        req_rx_valid_o  = '0;
        if (routed) begin
            grant_o[owner_q]         = 1'b1;
            req_cmd_ready_o[owner_q] = locked & core_command_ready_i;
            req_tx_ready_o[owner_q]  = core_tx_ready_i;
            req_rx_valid_o[owner_q]  = core_rx_valid_i;
        end
    end

    assign core_command_o       = locked ? req_cmd_i[owner_q] : '0;
    assign core_command_valid_o = locked & req_cmd_valid_i[owner_q];
    assign core_tx_data_o       = routed ? req_tx_data_i[owner_q] : '0;
    assign core_tx_be_o         = routed ? req_tx_be_i[owner_q] : '0;
    assign core_tx_valid_o      = routed & req_tx_valid_i[owner_q];
    assign core_rx_ready_o      = routed & req_rx_ready_i[owner_q];
    assign req_rx_data_o        = routed ? core_rx_data_i : '0;
    assign owner_o              = owner_q;
    assign busy_o               = routed;
endmodule

// File: doc/spi_host_arbiter.md
# spi_host_arbiter

Round-robin arbiter that shares one `spi_host_core` between `NumReq` independent requesters. Each requester has its own command queue and data FIFOs. The arbiter sits between those queues/FIFOs and the core's command, TX and RX stream ports. A grant is held across CSAAT-chained segments until the final segment (csaat=0) has been accepted and the core has gone idle, so a chip-select transaction is never interleaved.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters; must be ≥2.
- `CmdWidth`, default 64: width of the opaque packed command word.
- `IdxW`, default `$clog2(NumReq)`: width of the owner index.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `sw_rst_i` in 1: synchronous soft reset.
- `req_cmd_i` in NumReq×CmdWidth: per-requester command word.
- `req_csaat_i` in NumReq: per-requester csaat bit of that command.
- `req_cmd_valid_i` in NumReq / `req_cmd_ready_o` out NumReq: command handshake.
- `req_tx_data_i` in NumReq×32, `req_tx_be_i` in NumReq×4: TX word and byte enables.
- `req_tx_valid_i` in NumReq / `req_tx_ready_o` out NumReq: TX handshake.
- `req_rx_data_o` out 32: RX word, broadcast to all requesters.
- `req_rx_valid_o` out NumReq / `req_rx_ready_i` in NumReq: RX handshake.
- `core_command_o` out CmdWidth, `core_command_valid_o` out 1, `core_command_ready_i` in 1: core command port.
- `core_tx_data_o` out 32, `core_tx_be_o` out 4, `core_tx_valid_o` out 1, `core_tx_ready_i` in 1: core TX port.
- `core_rx_data_i` in 32, `core_rx_valid_i` in 1, `core_rx_ready_o` out 1: core RX port.
- `core_active_i` in 1: core `active_o`.
- `grant_o` out NumReq: one-hot owner, all zero when no owner.
- `owner_o` out IdxW: index of the current owner.
- `busy_o` out 1: high in Lock or Drain.

## Operation
- FSM states are Idle, Lock and Drain. Registers are state, `owner_q` and priority pointer `ptr_q`.
- **Idle**
  - All requester readies are 0, all `req_rx_valid_o` are 0, and all core valids are 0. `core_rx_ready_o` is 0.
  - If any `req_cmd_valid_i` is high, select the first index i with valid set, searching from `ptr_q` upward modulo NumReq.
  - On selection: `owner_q`←i, `ptr_q`←(i+1) mod NumReq, next state Lock.
  - Only command valids are considered; TX valids alone never request a grant.
- **Lock**
  - Combinationally mux the owner's command and TX lanes to the core.
  - Route the core's readies back only to the owner; non-owner readies stay 0.
  - `req_rx_valid_o[owner]`=`core_rx_valid_i`; all others are 0. `core_rx_ready_o`=`req_rx_ready_i[owner]`.
  - On a command handshake with `req_csaat_i[owner]`=0, go to Drain.
  - Handshakes with csaat=1 stay in Lock.
- **Drain**
  - Commands are blocked: `core_command_valid_o`=0 and the owner's `req_cmd_ready_o`=0.
  - TX and RX remain muxed to the owner.
  - The first Drain cycle ignores `core_active_i`.
  - From the second cycle on, the first cycle with `core_active_i`=0 returns the FSM to Idle.
- **Valid/ready rules:** requesters must hold valid and data stable until ready. The arbiter never drops valid mid-handshake except on reset.
- **sw_rst_i:** state→Idle, `owner_q`←0, `ptr_q`←0. sw_rst_i takes priority over every transition in the same cycle.
- **Reset values:** state Idle, `ptr_q`=0, `owner_q`=0, `grant_o`=0, `owner_o`=0, `busy_o`=0. All valid and ready outputs are 0 and all data outputs are 0.

## Timing
- **Grant latency:** valid sampled in Idle → `grant_o` and a forwarded `core_command_valid_o` in the next cycle. Minimum latency is 1 cycle.
- **Datapath:** muxes are combinational. There is no added pipeline latency on command, TX or RX while locked.
- **Minimum back-to-back ownership change:** handshake cycle, then ≥2 Drain cycles, then Idle (1 cycle), then new Lock.
- **Idle arbitration:** a valid arriving in the Idle cycle that follows Drain is arbitrated in that same cycle.
- **Core backpressure:** `core_command_ready_i`=0 holds the FSM in Lock with the command presented unchanged.
- **Reset mid-operation:** outputs drop to reset values immediately on async reset, and on the cycle after sw_rst_i. Requesters re-present pending commands afterwards.

## Test plan
- **Single requester:** from reset, req0 valid with csaat=0.
  - `grant_o`=01 one cycle later; command forwarded.
  - Core raises active for 5 cycles, then drops; `busy_o` falls the cycle after active drops.
- **Fairness:** req0 and req1 hold valid continuously with csaat=0 commands.
  - Grants alternate 0,1,0,1; `ptr_q` toggles accordingly.
  - No requester is granted twice in a row while the other waits.
- **CSAAT chain:** req0 sends segments with csaat=1,1,0 while req1 stays valid.
  - `grant_o` remains 01 through all three handshakes and Drain.
  - req1 is granted only after `core_active_i`=0.
- **RX isolation:** owner=req1; core pushes 0xDEADBEEF.
  - `req_rx_valid_o`=10; req0 never sees valid.
  - `req_rx_ready_i[0]`=1 has no effect on `core_rx_ready_o`.
- **Backpressure:** `core_command_ready_i` held 0 for 4 cycles in Lock.
  - Command and valid stay stable; state stays Lock; the handshake completes on cycle 5.
- **Soft reset mid-lock:** assert sw_rst_i during req1's TX burst.
  - Next cycle: `grant_o`=0, `busy_o`=0, all readies 0, `ptr_q`=0.
  - A subsequent simultaneous request grants req0.
